// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling 8-N-1 UART receiver with show-ahead byte FIFO (UART_RX_FIFO_EN selects FIFO vs single holding register)
module uart_rx_fifo #(
  parameter int FREQ_MHZ   = 12,
  parameter int BAUDS      = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic       rx_i,
  input  logic       rd_i,
  input  logic       clr_err_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       overrun_o
);
  localparam int CPB  = FREQ_MHZ * 1_000_000 / BAUDS;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] C_MID  = CW'(HALF - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [1:0] rx_q;
  logic rx_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  logic push, ferr, pop, wr, ovf;
  assign rx_s = rx_q[1];
  // two-flop synchroniser on the asynchronous line, idling high
  always_ff @(posedge clk)
    rx_q <= reset_i ? 2'b11 : {rx_q[0], rx_i};
  // receiver state, counters, shift register and frame-error pulse
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      sh          <= '0;
      frame_err_o <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      sh          <= sh_n;
      frame_err_o <= ferr;
    end
  end
  // next-state: validate start at half bit, then sample each bit mid-cell
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    push    = 1'b0;
    ferr    = 1'b0;
    case (state)
      IDLE: if (!rx_s) begin
        state_n = START;
        cnt_n   = '0;
      end
      START: if (cnt == C_MID) begin
        state_n = rx_s ? IDLE : DATA;
        cnt_n   = '0;
        idx_n   = '0;
      end else cnt_n = cnt + 1'b1;
      DATA: if (cnt == C_LAST) begin
        sh_n    = {rx_s, sh[7:1]};
        cnt_n   = '0;
        idx_n   = idx + 3'd1;
        state_n = (idx == 3'd7) ? STOP : DATA;
      end else cnt_n = cnt + 1'b1;
      default: if (cnt == C_LAST) begin
        push    = rx_s;
        ferr    = !rx_s;
        cnt_n   = '0;
        state_n = IDLE;
      end else cnt_n = cnt + 1'b1;
    endcase
  end
`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic full;
  assign full    = count == (AW+1)'(FIFO_DEPTH);
  assign valid_o = count != '0;
  assign pop     = rd_i && valid_o;
  assign wr      = push && (!full || pop);
  assign ovf     = push && full && !pop;
  assign data_o  = valid_o ? mem[rd_ptr] : 8'h00;
  // storage array; contents are qualified by count so it needs no reset
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= sh;
  // circular pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(wr) - (AW+1)'(pop);
    end
  end
`else
  localparam int UNUSED_DEPTH = FIFO_DEPTH;
  logic [7:0] hold;
  logic full;
  assign valid_o = full;
  assign pop     = rd_i && full;
  assign wr      = push && (!full || pop);
  assign ovf     = push && full && !pop;
  assign data_o  = full ? hold : 8'h00;
  // single-entry holding register keeps the old byte on overrun
  always_ff @(posedge clk) begin
    if (reset_i) begin
      full <= 1'b0;
      hold <= '0;
    end else begin
      full <= wr || (full && !pop);
      hold <= wr ? sh : hold;
    end
  end
`endif
  // sticky overrun; a fresh overrun wins over a simultaneous clear
  always_ff @(posedge clk)
    overrun_o <= reset_i ? 1'b0 : (ovf || (overrun_o && !clr_err_i));
endmodule
